// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing and the
// receive/transmit state encoding.
package uart_pkg;

  localparam int  CLKS_PER_BIT_DEFAULT = 10414;
  localparam real CLK_PERIOD_NS        = 10.0;

  localparam int  DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic logic [15:0] cnt_of(
    input int n
  );
    return 16'(n);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle: last byte plus its
// one-cycle valid / framing-error strobes.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_error;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_error
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_error
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous bit;
// both stages reset to the line idle level (1).
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, registered
// byte output with valid and framing-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      RxD,
  uart_rx_if.master rx
);

  localparam logic [15:0] HALF_M1 =
    cnt_of(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 =
    cnt_of(CLKS_PER_BIT - 1);

  logic rxd_s;

  logic [2:0]  state_d, state_q;
  logic [15:0] cnt_d, cnt_q;
  logic [2:0]  idx_d, idx_q;
  logic [7:0]  shift_d, shift_q;
  logic [7:0]  data_d, data_q;
  logic        valid_d, valid_q;
  logic        error_d, error_q;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (RxD),
    .q     (rxd_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxd_s) begin
          state_d = ST_START;
        end
      end

      // Re-check the start bit at its midpoint to
      // reject glitches shorter than half a bit.
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          if (!rxd_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxd_s;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_BREAK: begin
        cnt_d = '0;
        idx_d = '0;
        if (rxd_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;
  assign rx.rx_error = error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level line driver
// feeds an expectation queue checked every clock.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;
  int   cyc   = 0;

  int checks = 0;
  int errors = 0;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .RxD   (rxd),
    .rx    (rx_if)
  );

  always #(CLK_PERIOD_NS / 2.0) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         lo;
    int         hi;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  int         pulse_cyc[$];
  logic [7:0] model_data = 8'h00;

  // Stop-bit decision lands ~CPB/2+9*CPB plus sync and
  // register latency after the line edge.
  always @(negedge clk) begin : compare
    exp_t e;
    if (reset) begin
      model_data = 8'h00;
    end else begin
      if (rx_if.rx_valid || rx_if.rx_error) begin
        checks++;
        if (rx_if.rx_valid && rx_if.rx_error) begin
          errors++;
          $display("FAIL both_pulses cyc=%0d", cyc);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse valid=%0b err=%0b cyc=%0d",
                   rx_if.rx_valid, rx_if.rx_error, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.err != rx_if.rx_error ||
              cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL pulse actual err=%0b cyc=%0d required err=%0b cyc=%0d..%0d",
                     rx_if.rx_error, cyc, e.err, e.lo, e.hi);
          end
          if (!e.err) begin
            model_data = e.data;
            got_q.push_back(rx_if.rx_data);
            pulse_cyc.push_back(cyc);
          end
        end
      end
      checks++;
      if (rx_if.rx_data !== model_data) begin
        errors++;
        $display("FAIL rx_data actual=%02h required=%02h cyc=%0d",
                 rx_if.rx_data, model_data, cyc);
      end
    end
  end

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  // Drives one frame at a possibly fractional bit period;
  // abort_bit >= 0 resets the DUT mid-way through that bit.
  task automatic send_frame(
    input logic [7:0] d,
    input real        per,
    input bit         stop,
    input int         abort_bit
  );
    logic [9:0] bits;
    exp_t       e;
    int         prev;
    int         nxt;
    bits = {stop, d, 1'b0};
    prev = 0;
    if (abort_bit < 0) begin
      e.err  = !stop;
      e.data = d;
      e.lo   = cyc + 150;
      e.hi   = cyc + 160;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      if (k == abort_bit) begin
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        return;
      end
      nxt = int'($floor((k + 1) * per + 0.5));
      repeat (nxt - prev) @(negedge clk);
      prev = nxt;
    end
  endtask

  function automatic logic [7:0] last_got();
    if (got_q.size() == 0) return 8'hxx;
    return got_q[got_q.size() - 1];
  endfunction

  initial begin : watchdog
    #(200000.0 * CLK_PERIOD_NS);
    errors++;
    $display("FAIL watchdog cyc=%0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0;
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_rx_data", 32'(rx_if.rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_if.rx_valid), 32'h0);
    chk("reset_rx_error", 32'(rx_if.rx_error), 32'h0);
    reset = 1'b0;
    idle_bits(2);

    send_frame(8'hAB, real'(CPB), 1'b1, -1);
    idle_bits(2);
    send_frame(8'hCD, real'(CPB), 1'b1, -1);
    idle_bits(2);
    send_frame(8'hEF, real'(CPB), 1'b1, -1);
    idle_bits(2);
    chk("loop_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("loop_byte0", 32'(got_q[0]), 32'hAB);
      chk("loop_byte1", 32'(got_q[1]), 32'hCD);
      chk("loop_byte2", 32'(got_q[2]), 32'hEF);
    end

    n0 = got_q.size();
    send_frame(8'h00, real'(CPB), 1'b1, -1);
    send_frame(8'hFF, real'(CPB), 1'b1, -1);
    idle_bits(2);
    chk("b2b_count", 32'(got_q.size() - n0), 32'd2);
    if (got_q.size() == n0 + 2) begin
      chk("b2b_byte0", 32'(got_q[n0]), 32'h00);
      chk("b2b_byte1", 32'(got_q[n0 + 1]), 32'hFF);
      chk("b2b_spacing",
          32'(pulse_cyc[n0 + 1] - pulse_cyc[n0]), 32'd160);
    end

    n0 = got_q.size();
    rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rxd = 1'b1;
    idle_bits(3);
    chk("glitch_count", 32'(got_q.size() - n0), 32'd0);
    chk("glitch_rx_data", 32'(rx_if.rx_data), 32'hFF);

    n0 = got_q.size();
    send_frame(8'h55, real'(CPB), 1'b0, -1);
    idle_bits(3);
    chk("ferr_pending", 32'(exp_q.size()), 32'd0);
    chk("ferr_count", 32'(got_q.size() - n0), 32'd0);
    chk("ferr_rx_data", 32'(rx_if.rx_data), 32'hFF);
    rxd = 1'b1;
    idle_bits(2);
    send_frame(8'h3C, real'(CPB), 1'b1, -1);
    idle_bits(2);
    chk("after_ferr_byte", 32'(last_got()), 32'h3C);

    n0 = got_q.size();
    send_frame(8'hA5, real'(CPB), 1'b1, 5);
    chk("abort_rx_data", 32'(rx_if.rx_data), 32'h00);
    idle_bits(2);
    send_frame(8'h5A, real'(CPB), 1'b1, -1);
    idle_bits(2);
    chk("abort_count", 32'(got_q.size() - n0), 32'd1);
    chk("abort_next_byte", 32'(last_got()), 32'h5A);

    send_frame(8'h96, real'(CPB) * 1.02, 1'b1, -1);
    idle_bits(2);
    chk("slow_byte", 32'(last_got()), 32'h96);
    n0 = got_q.size();
    send_frame(8'h96, real'(CPB) * 0.98, 1'b1, -1);
    idle_bits(2);
    chk("fast_count", 32'(got_q.size() - n0), 32'd1);
    chk("fast_byte", 32'(last_got()), 32'h96);

    chk("pending_final", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
